// File: rtl/ram_port_arbiter.sv
// Shares one single-port, 1-cycle-latency word RAM between instruction fetch and load/store.
// Partial stores become a read-modify-write pair: read the word, then write the merged word.
module ram_port_arbiter #(
    parameter int SIZE        = 512,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_we,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_e;

    localparam logic GRANT_INSTR = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    if (SIZE < 1) begin : g_size_invalid
    end

    // Per byte lane: take the store byte where enabled, otherwise keep the byte just read.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lane_en);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (lane_en[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        i_rvalid_q, i_rvalid_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic [31:0] merge_addr_q, merge_addr_d;

    logic        d_read_s, d_full_s, d_part_s;
    logic        d_win_s, i_win_s;
    logic [31:0] i_word_s, d_word_s;
    logic        i_gnt_s, d_gnt_s;
    logic [31:0] ram_addr_s, ram_wdata_s;
    logic [3:0]  ram_we_s;
    logic        unused_addr_bits_s;

    assign i_word_s = {2'b00, i_addr[31:2]};
    assign d_word_s = {2'b00, d_addr[31:2]};
    assign unused_addr_bits_s = ^{i_addr[1:0], d_addr[1:0]};

    assign d_read_s = (d_we == 4'h0);
    assign d_full_s = (d_we == 4'hF);
    assign d_part_s = !d_read_s && !d_full_s;

    // Data wins when alone, when ties always favour it, or when instr was granted last.
    assign d_win_s = d_req && (!i_req || (ROUND_ROBIN == 1'b0) || (last_grant_q == GRANT_INSTR));
    assign i_win_s = i_req && !d_win_s;

    // State register and registered read-valid strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_INSTR;
            i_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            merge_addr_q <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            i_rvalid_q   <= i_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            merge_addr_q <= merge_addr_d;
        end
    end

    // Next-state, fairness pointer and read-valid computation.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        i_rvalid_d   = 1'b0;
        d_rvalid_d   = 1'b0;
        merge_addr_d = merge_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (d_win_s) begin
                    last_grant_d = GRANT_DATA;
                    merge_addr_d = d_word_s;
                    if (d_read_s) begin
                        d_rvalid_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else if (d_part_s) begin
                        state_d = ST_MERGE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (i_win_s) begin
                    last_grant_d = GRANT_INSTR;
                    i_rvalid_d   = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MERGE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Grants and RAM command for the current cycle.
    always_comb begin
        i_gnt_s     = 1'b0;
        d_gnt_s     = 1'b0;
        ram_addr_s  = i_word_s;
        ram_wdata_s = d_wdata;
        ram_we_s    = 4'h0;
        case (state_q)
            ST_IDLE: begin
                if (d_win_s) begin
                    ram_addr_s = d_word_s;
                    if (d_read_s) begin
                        d_gnt_s = 1'b1;
                    end else if (d_full_s) begin
                        d_gnt_s  = 1'b1;
                        ram_we_s = 4'hF;
                    end else begin
                        d_gnt_s  = 1'b0;
                        ram_we_s = 4'h0;
                    end
                end else if (i_win_s) begin
                    i_gnt_s    = 1'b1;
                    ram_addr_s = i_word_s;
                end else begin
                    ram_addr_s = i_word_s;
                end
            end
            ST_MERGE: begin
                ram_addr_s  = merge_addr_q;
                ram_wdata_s = merge_bytes(ram_rdata, d_wdata, d_we);
                ram_we_s    = 4'hF;
                d_gnt_s     = d_req;
            end
            default: begin
                ram_we_s = 4'h0;
            end
        endcase
    end

    // Reset must block any grant or write even before the state flops settle.
    assign i_gnt     = i_gnt_s & rst_n;
    assign d_gnt     = d_gnt_s & rst_n;
    assign ram_we    = rst_n ? ram_we_s : 4'h0;
    assign ram_addr  = ram_addr_s;
    assign ram_wdata = ram_wdata_s;
    assign i_rvalid  = i_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign i_rdata   = ram_rdata;
    assign d_rdata   = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: round-robin instance on a RAM model,
// plus a data-priority instance used for the tie-break check.
module tb_ram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wdata;

    logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
    logic [31:0] i_rdata, d_rdata, ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_we;

    logic        i_gnt0, i_rvalid0, d_gnt0, d_rvalid0;
    logic [31:0] i_rdata0, d_rdata0, ram_addr0, ram_wdata0, ram_rdata0;
    logic [3:0]  ram_we0;

    logic [31:0] mem [0:511];
    logic [31:0] exp_words [0:3];

    int total;
    int bad;

    ram_port_arbiter #(.SIZE(512), .ROUND_ROBIN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    ram_port_arbiter #(.SIZE(512), .ROUND_ROBIN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt0), .i_rvalid(i_rvalid0), .i_rdata(i_rdata0),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt0), .d_rvalid(d_rvalid0), .d_rdata(d_rdata0),
        .ram_addr(ram_addr0), .ram_wdata(ram_wdata0), .ram_we(ram_we0), .ram_rdata(ram_rdata0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read of the pre-write contents, whole-word write.
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr[8:0]];
        if (ram_we != 4'h0) begin
            mem[ram_addr[8:0]] = ram_wdata;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        i_req = 1'b0;
        d_req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_addr = 32'h0; d_we = 4'h0; d_wdata = 32'h0;
        ram_rdata0 = 32'h0;
        for (int w = 0; w < 512; w++) mem[w] = 32'h0;
        exp_words[0] = 32'hA0A0_A0A0;
        exp_words[1] = 32'hB1B1_B1B1;
        exp_words[2] = 32'h1122_3344;
        exp_words[3] = 32'hC3C3_C3C3;
        for (int w = 0; w < 4; w++) mem[w] = exp_words[w];
        mem[4] = 32'hDEAD_BEEF;
        mem[5] = 32'h5555_5555;

        // Requests during reset must not be granted or written.
        #3;
        i_req = 1'b1; d_req = 1'b1; d_we = 4'hF; d_addr = 32'h40;
        #1;
        check_val("rst_i_gnt", i_gnt, 32'd0);
        check_val("rst_d_gnt", d_gnt, 32'd0);
        check_val("rst_ram_we", ram_we, 32'd0);
        check_val("rst_i_rvalid", i_rvalid, 32'd0);
        check_val("rst_d_rvalid", d_rvalid, 32'd0);
        i_req = 1'b0; d_req = 1'b0; d_we = 4'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single instruction read.
        next_cycle();
        i_req = 1'b1; i_addr = 32'h10;
        @(negedge clk);
        check_val("rd_i_gnt", i_gnt, 32'd1);
        check_val("rd_ram_addr", ram_addr, 32'd4);
        check_val("rd_ram_we", ram_we, 32'd0);
        next_cycle();
        i_req = 1'b0;
        @(negedge clk);
        check_val("rd_i_rvalid", i_rvalid, 32'd1);
        check_val("rd_i_rdata", i_rdata, 32'hDEAD_BEEF);
        check_val("rd_i_gnt_idle", i_gnt, 32'd0);

        // Back-to-back reads of words 0..3.
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            i_req = 1'b1; i_addr = 32'(4 * k);
            @(negedge clk);
            check_val("burst_gnt", i_gnt, 32'd1);
            check_val("burst_addr", ram_addr, 32'(k));
            if (k > 0) begin
                check_val("burst_rvalid", i_rvalid, 32'd1);
                check_val("burst_rdata", i_rdata, exp_words[k-1]);
            end
        end
        next_cycle();
        i_req = 1'b0;
        @(negedge clk);
        check_val("burst_last_rvalid", i_rvalid, 32'd1);
        check_val("burst_last_rdata", i_rdata, exp_words[3]);
        next_cycle();
        @(negedge clk);
        check_val("burst_rvalid_off", i_rvalid, 32'd0);

        // Tie from reset: round-robin alternates D,I,...; data-priority always D.
        do_reset();
        d_we = 4'h0; d_addr = 32'h8; i_addr = 32'h0;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            i_req = 1'b1; d_req = 1'b1;
            @(negedge clk);
            check_val("rr_d_gnt", d_gnt, (c % 2 == 0) ? 32'd1 : 32'd0);
            check_val("rr_i_gnt", i_gnt, (c % 2 == 1) ? 32'd1 : 32'd0);
            check_val("fix_d_gnt", d_gnt0, 32'd1);
            check_val("fix_i_gnt", i_gnt0, 32'd0);
        end
        next_cycle();
        i_req = 1'b0; d_req = 1'b0;

        // Partial store into word 2, then read it back.
        next_cycle();
        d_req = 1'b1; d_addr = 32'h8; d_we = 4'b0010; d_wdata = 32'h0000_AB00;
        @(negedge clk);
        check_val("ps0_d_gnt", d_gnt, 32'd0);
        check_val("ps0_ram_we", ram_we, 32'd0);
        check_val("ps0_ram_addr", ram_addr, 32'd2);
        next_cycle();
        @(negedge clk);
        check_val("ps1_ram_we", ram_we, 32'hF);
        check_val("ps1_ram_wdata", ram_wdata, 32'h1122_AB44);
        check_val("ps1_d_gnt", d_gnt, 32'd1);
        check_val("ps1_ram_addr", ram_addr, 32'd2);
        next_cycle();
        d_we = 4'h0;
        @(negedge clk);
        check_val("ps_rd_gnt", d_gnt, 32'd1);
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        check_val("ps_rd_rvalid", d_rvalid, 32'd1);
        check_val("ps_rd_rdata", d_rdata, 32'h1122_AB44);

        // Full store then immediate read of the same word.
        next_cycle();
        d_req = 1'b1; d_addr = 32'h20; d_we = 4'hF; d_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        check_val("fs_d_gnt", d_gnt, 32'd1);
        check_val("fs_ram_we", ram_we, 32'hF);
        check_val("fs_ram_wdata", ram_wdata, 32'hCAFE_F00D);
        check_val("fs_ram_addr", ram_addr, 32'd8);
        next_cycle();
        d_we = 4'h0;
        @(negedge clk);
        check_val("fs_rd_gnt", d_gnt, 32'd1);
        check_val("fs_rd_ram_we", ram_we, 32'd0);
        check_val("fs_no_rvalid", d_rvalid, 32'd0);
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        check_val("fs_rd_rvalid", d_rvalid, 32'd1);
        check_val("fs_rd_rdata", d_rdata, 32'hCAFE_F00D);

        // Instruction request stalled across a partial store.
        next_cycle();
        i_req = 1'b1; i_addr = 32'h0;
        @(negedge clk);
        check_val("st_pre_i_gnt", i_gnt, 32'd1);
        next_cycle();
        i_addr = 32'h10;
        d_req = 1'b1; d_addr = 32'hC; d_we = 4'b1000; d_wdata = 32'hEE00_0000;
        @(negedge clk);
        check_val("st0_i_gnt", i_gnt, 32'd0);
        check_val("st0_d_gnt", d_gnt, 32'd0);
        check_val("st0_ram_we", ram_we, 32'd0);
        next_cycle();
        @(negedge clk);
        check_val("st1_i_gnt", i_gnt, 32'd0);
        check_val("st1_d_gnt", d_gnt, 32'd1);
        check_val("st1_ram_wdata", ram_wdata, 32'hEEC3_C3C3);
        next_cycle();
        d_we = 4'h0; d_addr = 32'h0;
        @(negedge clk);
        check_val("st2_i_gnt", i_gnt, 32'd1);
        check_val("st2_d_gnt", d_gnt, 32'd0);
        check_val("st2_ram_addr", ram_addr, 32'd4);
        next_cycle();
        i_req = 1'b0;
        @(negedge clk);
        check_val("st3_d_gnt", d_gnt, 32'd1);
        check_val("st3_i_rvalid", i_rvalid, 32'd1);
        check_val("st3_i_rdata", i_rdata, 32'hDEAD_BEEF);
        next_cycle();
        d_req = 1'b0;

        // Reset asserted in the merge cycle abandons the write.
        next_cycle();
        d_req = 1'b1; d_addr = 32'h14; d_we = 4'b0001; d_wdata = 32'h0000_00FF;
        @(negedge clk);
        check_val("rm0_d_gnt", d_gnt, 32'd0);
        next_cycle();
        check_val("rm1_ram_we", ram_we, 32'hF);
        #1;
        rst_n = 1'b0;
        d_req = 1'b0; d_we = 4'h0;
        #1;
        check_val("rm_rst_ram_we", ram_we, 32'd0);
        check_val("rm_rst_d_gnt", d_gnt, 32'd0);
        next_cycle();
        check_val("rm_word_kept", mem[5], 32'h5555_5555);
        check_val("rm_i_rvalid", i_rvalid, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        i_req = 1'b1; i_addr = 32'h14;
        @(negedge clk);
        check_val("rm_post_i_gnt", i_gnt, 32'd1);
        check_val("rm_post_addr", ram_addr, 32'd5);
        check_val("rm_post_ram_we", ram_we, 32'd0);
        next_cycle();
        i_req = 1'b0;
        @(negedge clk);
        check_val("rm_post_rvalid", i_rvalid, 32'd1);
        check_val("rm_post_rdata", i_rdata, 32'h5555_5555);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
